// File: rtl/sdram_port_arbiter.sv
// Burst-granular arbiter sharing one Avalon-MM SDRAM host port between the frame
// write channel and the frame read channel, with an outstanding-read-beat limit.
module sdram_port_arbiter #(
    parameter  int ADDR_W       = 29,
    parameter  int DATA_W       = 64,
    parameter  int BURST_W      = 8,
    parameter  int MAX_RD_BEATS = 256,
    localparam int BE_W         = DATA_W / 8,
    localparam int OUT_W        = $clog2(MAX_RD_BEATS) + 1
) (
    input  logic               clk_100,
    input  logic               reset_n,
    input  logic               wr_write,
    input  logic [ADDR_W-1:0]  wr_address,
    input  logic [BURST_W-1:0] wr_burstcount,
    input  logic [DATA_W-1:0]  wr_writedata,
    input  logic [BE_W-1:0]    wr_byteenable,
    output logic               wr_waitrequest,
    input  logic               rd_read,
    input  logic [ADDR_W-1:0]  rd_address,
    input  logic [BURST_W-1:0] rd_burstcount,
    output logic               rd_waitrequest,
    output logic [DATA_W-1:0]  rd_readdata,
    output logic               rd_readdatavalid,
    output logic               sd_write,
    output logic               sd_read,
    output logic [ADDR_W-1:0]  sd_address,
    output logic [BURST_W-1:0] sd_burstcount,
    output logic [DATA_W-1:0]  sd_writedata,
    output logic [BE_W-1:0]    sd_byteenable,
    input  logic               sd_waitrequest,
    input  logic [DATA_W-1:0]  sd_readdata,
    input  logic               sd_readdatavalid,
    output logic               busy,
    output logic               err_zero_burst,
    output logic [1:0]         o_dbg_state,
    output logic [OUT_W-1:0]   o_dbg_rd_outstanding
);
    localparam int SUM_W = OUT_W + 1;

    // Handshake: a command/beat transfers on a clock edge where the master holds
    // its request (sd_write or sd_read) high and sd_waitrequest is low.
    typedef enum logic [1:0] {IDLE = 2'd0, WR_BURST = 2'd1, RD_CMD = 2'd2} state_t;

    state_t             r_state;
    logic               r_last_wr;
    logic               r_wr_first;
    logic [BURST_W-1:0] r_wr_beats_left;
    logic [BURST_W-1:0] r_wr_burst;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [OUT_W-1:0]   r_rd_out;
    logic               r_err_zero;

    logic               w_wr_zero;
    logic               w_rd_zero;
    logic [BURST_W-1:0] w_wr_eff;
    logic [BURST_W-1:0] w_rd_eff;
    logic [SUM_W-1:0]   w_rd_sum;
    logic               w_rd_eligible;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_wr_last;
    logic [OUT_W-1:0]   w_rd_inc;
    logic [OUT_W-1:0]   w_rd_dec;

    assign w_wr_zero     = (wr_burstcount == '0);
    assign w_rd_zero     = (rd_burstcount == '0);
    assign w_wr_eff      = w_wr_zero ? BURST_W'(1) : wr_burstcount;
    assign w_rd_eff      = w_rd_zero ? BURST_W'(1) : rd_burstcount;
    assign w_rd_sum      = SUM_W'(r_rd_out) + SUM_W'(w_rd_eff);
    assign w_rd_eligible = rd_read && (w_rd_sum <= SUM_W'(MAX_RD_BEATS));
    assign w_wr_acc      = sd_write && !sd_waitrequest;
    assign w_rd_acc      = sd_read && !sd_waitrequest;
    assign w_wr_last     = w_wr_acc && (r_wr_first ? (w_wr_eff == BURST_W'(1))
                                                   : (r_wr_beats_left == BURST_W'(1)));
    assign w_rd_inc      = w_rd_acc ? OUT_W'(w_rd_eff) : '0;
    // A stray return beat with nothing outstanding must not wrap the counter.
    assign w_rd_dec      = (sd_readdatavalid && (r_rd_out != '0)) ? OUT_W'(1) : '0;

    always_comb begin
        sd_write       = 1'b0;
        sd_read        = 1'b0;
        sd_address     = rd_address;
        sd_burstcount  = w_rd_eff;
        sd_writedata   = wr_writedata;
        sd_byteenable  = wr_byteenable;
        wr_waitrequest = 1'b1;
        rd_waitrequest = 1'b1;
        case (r_state)
            WR_BURST: begin
                sd_write       = wr_write;
                sd_address     = r_wr_first ? wr_address : r_wr_addr;
                sd_burstcount  = r_wr_first ? w_wr_eff : r_wr_burst;
                wr_waitrequest = sd_waitrequest;
            end
            RD_CMD: begin
                sd_read        = rd_read;
                rd_waitrequest = sd_waitrequest;
            end
            default: ;
        endcase
    end

    assign rd_readdata          = sd_readdata;
    assign rd_readdatavalid     = sd_readdatavalid;
    assign busy                 = (r_state == WR_BURST) || (r_rd_out != '0);
    assign err_zero_burst       = r_err_zero;
    assign o_dbg_state          = r_state;
    assign o_dbg_rd_outstanding = r_rd_out;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_last_wr       <= 1'b0;
            r_wr_first      <= 1'b1;
            r_wr_beats_left <= '0;
            r_wr_burst      <= '0;
            r_wr_addr       <= '0;
            r_rd_out        <= '0;
            r_err_zero      <= 1'b0;
        end else begin
            r_rd_out <= r_rd_out + w_rd_inc - w_rd_dec;
            if ((w_wr_acc && r_wr_first && w_wr_zero) || (w_rd_acc && w_rd_zero))
                r_err_zero <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_wr_first <= 1'b1;
                    if (wr_write && w_rd_eligible)
                        r_state <= r_last_wr ? RD_CMD : WR_BURST;
                    else if (wr_write)
                        r_state <= WR_BURST;
                    else if (w_rd_eligible)
                        r_state <= RD_CMD;
                end
                WR_BURST: begin
                    if (w_wr_acc) begin
                        r_last_wr <= 1'b1;
                        if (r_wr_first) begin
                            r_wr_first      <= 1'b0;
                            r_wr_beats_left <= w_wr_eff - BURST_W'(1);
                            r_wr_burst      <= w_wr_eff;
                            r_wr_addr       <= wr_address;
                        end else begin
                            r_wr_beats_left <= r_wr_beats_left - BURST_W'(1);
                        end
                        // Hand straight to a waiting read so the port never idles.
                        if (w_wr_last) begin
                            r_wr_first <= 1'b1;
                            r_state    <= w_rd_eligible ? RD_CMD : IDLE;
                        end
                    end
                end
                RD_CMD: begin
                    if (w_rd_acc) begin
                        r_last_wr <= 1'b0;
                        r_state   <= wr_write ? WR_BURST : IDLE;
                    end else if (!rd_read) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized scenario bench for sdram_port_arbiter with a transaction-level
// model of expected write beats and outstanding read beats.
module tb_sdram_port_arbiter;
    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BURST_W = 8;
    localparam int MAX_RD = 256;
    localparam int BE_W = DATA_W / 8;
    localparam int OUT_W = $clog2(MAX_RD) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;

    logic               clk_100;
    logic               reset_n;
    logic               wr_write;
    logic [ADDR_W-1:0]  wr_address;
    logic [BURST_W-1:0] wr_burstcount;
    logic [DATA_W-1:0]  wr_writedata;
    logic [BE_W-1:0]    wr_byteenable;
    logic               wr_waitrequest;
    logic               rd_read;
    logic [ADDR_W-1:0]  rd_address;
    logic [BURST_W-1:0] rd_burstcount;
    logic               rd_waitrequest;
    logic [DATA_W-1:0]  rd_readdata;
    logic               rd_readdatavalid;
    logic               sd_write;
    logic               sd_read;
    logic [ADDR_W-1:0]  sd_address;
    logic [BURST_W-1:0] sd_burstcount;
    logic [DATA_W-1:0]  sd_writedata;
    logic [BE_W-1:0]    sd_byteenable;
    logic               sd_waitrequest;
    logic [DATA_W-1:0]  sd_readdata;
    logic               sd_readdatavalid;
    logic               busy;
    logic               err_zero_burst;
    logic [1:0]         o_dbg_state;
    logic [OUT_W-1:0]   o_dbg_rd_outstanding;

    int n_checks = 0;
    int n_pass = 0;
    int exp_out = 0;
    logic [DATA_W-1:0] exp_q[$];

    sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
                         .MAX_RD_BEATS(MAX_RD)) dut (
        .clk_100(clk_100), .reset_n(reset_n),
        .wr_write(wr_write), .wr_address(wr_address), .wr_burstcount(wr_burstcount),
        .wr_writedata(wr_writedata), .wr_byteenable(wr_byteenable),
        .wr_waitrequest(wr_waitrequest),
        .rd_read(rd_read), .rd_address(rd_address), .rd_burstcount(rd_burstcount),
        .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
        .rd_readdatavalid(rd_readdatavalid),
        .sd_write(sd_write), .sd_read(sd_read), .sd_address(sd_address),
        .sd_burstcount(sd_burstcount), .sd_writedata(sd_writedata),
        .sd_byteenable(sd_byteenable), .sd_waitrequest(sd_waitrequest),
        .sd_readdata(sd_readdata), .sd_readdatavalid(sd_readdatavalid),
        .busy(busy), .err_zero_burst(err_zero_burst),
        .o_dbg_state(o_dbg_state), .o_dbg_rd_outstanding(o_dbg_rd_outstanding)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Let combinational outputs settle, then update the outstanding-beat model.
    task automatic settle();
        int dec;
        #1;
        dec = (sd_readdatavalid && exp_out > 0) ? 1 : 0;
        if (sd_read && !sd_waitrequest)
            exp_out += (rd_burstcount == 0) ? 1 : int'(rd_burstcount);
        exp_out -= dec;
    endtask

    task automatic tick();
        @(posedge clk_100);
        #1;
    endtask

    task automatic idle_inputs();
        wr_write = 0; wr_address = '0; wr_burstcount = '0; wr_writedata = '0;
        wr_byteenable = '1; rd_read = 0; rd_address = '0; rd_burstcount = '0;
        sd_waitrequest = 0; sd_readdata = '0; sd_readdatavalid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        exp_out = 0;
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            sd_readdatavalid = 1; sd_readdata = {$urandom, $urandom};
            settle(); tick();
        end
        sd_readdatavalid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        wr_write = 1; rd_read = 1; rd_burstcount = 8'd4;
        tick();
        settle();
        n_checks++; if (sd_write !== 1'b0) $display("FAIL reset_sd_write: got %b want 0", sd_write); else n_pass++;
        n_checks++; if (sd_read !== 1'b0) $display("FAIL reset_sd_read: got %b want 0", sd_read); else n_pass++;
        n_checks++; if (wr_waitrequest !== 1'b1) $display("FAIL reset_wr_wait: got %b want 1", wr_waitrequest); else n_pass++;
        n_checks++; if (rd_waitrequest !== 1'b1) $display("FAIL reset_rd_wait: got %b want 1", rd_waitrequest); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rd_readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %b want 0", rd_readdatavalid); else n_pass++;
        n_checks++; if (err_zero_burst !== 1'b0) $display("FAIL reset_err: got %b want 0", err_zero_burst); else n_pass++;
        n_checks++; if (o_dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want 0", o_dbg_state); else n_pass++;
        n_checks++; if (o_dbg_rd_outstanding !== '0) $display("FAIL reset_out: got %0d want 0", o_dbg_rd_outstanding); else n_pass++;
        idle_inputs();
        reset_n = 1;
        tick();
    endtask

    task automatic test_write_only();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d[32];
        logic [DATA_W-1:0] e;
        int beats = 0, cycles = 0, stalls = 3;
        a = ADDR_W'($urandom);
        for (int i = 0; i < 32; i++) begin
            d[i] = {$urandom, $urandom};
            exp_q.push_back(d[i]);
        end
        wr_write = 1; wr_address = a; wr_burstcount = 8'd32; wr_writedata = d[0];
        settle();
        n_checks++; if (sd_write !== 1'b0) $display("FAIL wo_latency: sd_write got %b want 0", sd_write); else n_pass++;
        tick();
        while (beats < 32 && cycles < 100) begin
            wr_writedata = d[beats];
            if (beats > 0) wr_address = ADDR_W'($urandom);
            sd_waitrequest = 0;
            if (stalls > 0 && beats > 0 && $urandom_range(0, 4) == 0) begin
                sd_waitrequest = 1; stalls--;
            end
            settle();
            if (sd_write && !sd_waitrequest) begin
                e = exp_q.pop_front();
                n_checks++; if (sd_writedata !== e) $display("FAIL wo_data[%0d]: got %h want %h", beats, sd_writedata, e); else n_pass++;
                n_checks++; if (sd_address !== a) $display("FAIL wo_addr[%0d]: got %h want %h", beats, sd_address, a); else n_pass++;
                beats++;
            end
            tick();
            cycles++;
        end
        n_checks++; if (beats != 32) $display("FAIL wo_beats: got %0d want 32", beats); else n_pass++;
        sd_waitrequest = 0;
        settle();
        n_checks++; if (sd_write !== 1'b0) $display("FAIL wo_extra_beat: sd_write got %b want 0", sd_write); else n_pass++;
        n_checks++; if (wr_waitrequest !== 1'b1) $display("FAIL wo_release: wr_wait got %b want 1", wr_waitrequest); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL wo_busy: got %b want 0", busy); else n_pass++;
        wr_write = 0;
    endtask

    task automatic test_simultaneous();
        logic [ADDR_W-1:0] wa, wa2, ra;
        logic [DATA_W-1:0] d, rv;
        do_reset();
        wa = ADDR_W'($urandom); wa2 = ADDR_W'($urandom); ra = ADDR_W'($urandom);
        wr_write = 1; wr_address = wa; wr_burstcount = 8'd4;
        rd_read = 1; rd_address = ra; rd_burstcount = 8'd8;
        settle();
        n_checks++; if ({sd_write, sd_read} !== 2'b00) $display("FAIL sim_latency: got %b want 00", {sd_write, sd_read}); else n_pass++;
        tick();
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            wr_writedata = d;
            settle();
            n_checks++; if ({sd_write, sd_read, rd_waitrequest} !== 3'b101) $display("FAIL sim_wr_beat%0d: got %b want 101", i, {sd_write, sd_read, rd_waitrequest}); else n_pass++;
            n_checks++; if (sd_writedata !== d) $display("FAIL sim_wr_data%0d: got %h want %h", i, sd_writedata, d); else n_pass++;
            tick();
        end
        wr_address = wa2; wr_burstcount = 8'd1;
        settle();
        n_checks++; if ({sd_read, sd_write, rd_waitrequest, wr_waitrequest} !== 4'b1001) $display("FAIL sim_rd_cmd: got %b want 1001", {sd_read, sd_write, rd_waitrequest, wr_waitrequest}); else n_pass++;
        n_checks++; if (sd_address !== ra) $display("FAIL sim_rd_addr: got %h want %h", sd_address, ra); else n_pass++;
        n_checks++; if (sd_burstcount !== 8'd8) $display("FAIL sim_rd_burst: got %0d want 8", sd_burstcount); else n_pass++;
        tick();
        rd_read = 0;
        d = {$urandom, $urandom};
        wr_writedata = d;
        settle();
        n_checks++; if (sd_write !== 1'b1) $display("FAIL sim_rr_write: got %b want 1", sd_write); else n_pass++;
        n_checks++; if (sd_address !== wa2) $display("FAIL sim_rr_addr: got %h want %h", sd_address, wa2); else n_pass++;
        tick();
        wr_write = 0;
        settle();
        n_checks++; if (o_dbg_state !== S_IDLE) $display("FAIL sim_idle: got %0d want 0", o_dbg_state); else n_pass++;
        n_checks++; if (o_dbg_rd_outstanding !== OUT_W'(exp_out)) $display("FAIL sim_out: got %0d want %0d", o_dbg_rd_outstanding, exp_out); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL sim_busy: got %b want 1", busy); else n_pass++;
        tick();
        for (int i = 0; i < 8; i++) begin
            rv = {$urandom, $urandom};
            sd_readdatavalid = 1; sd_readdata = rv;
            settle();
            n_checks++; if (rd_readdatavalid !== 1'b1 || rd_readdata !== rv) $display("FAIL sim_rdata%0d: got %b/%h want 1/%h", i, rd_readdatavalid, rd_readdata, rv); else n_pass++;
            tick();
        end
        sd_readdatavalid = 0;
        settle();
        n_checks++; if (o_dbg_rd_outstanding !== OUT_W'(exp_out)) $display("FAIL sim_drained: got %0d want %0d", o_dbg_rd_outstanding, exp_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL sim_busy_end: got %b want 0", busy); else n_pass++;
        tick();
    endtask

    task automatic test_write_hold();
        int beats = 0, gap = 0, cycles = 0;
        wr_write = 1; wr_address = ADDR_W'($urandom); wr_burstcount = 8'd16;
        settle(); tick();
        rd_read = 1; rd_address = ADDR_W'($urandom); rd_burstcount = 8'd4;
        while (beats < 16 && cycles < 60) begin
            if (beats == 6 && gap < 5) begin
                wr_write = 0; gap++;
            end else begin
                wr_write = 1;
            end
            wr_writedata = {$urandom, $urandom};
            settle();
            n_checks++; if ({sd_read, rd_waitrequest} !== 2'b01) $display("FAIL hold_no_read c%0d: got %b want 01", cycles, {sd_read, rd_waitrequest}); else n_pass++;
            if (sd_write && !sd_waitrequest) beats++;
            tick();
            cycles++;
        end
        n_checks++; if (beats != 16) $display("FAIL hold_beats: got %0d want 16", beats); else n_pass++;
        wr_write = 0;
        settle();
        n_checks++; if ({sd_read, rd_waitrequest} !== 2'b10) $display("FAIL hold_read_after: got %b want 10", {sd_read, rd_waitrequest}); else n_pass++;
        tick();
        rd_read = 0;
        drain(4);
        settle();
        n_checks++; if (o_dbg_rd_outstanding !== OUT_W'(exp_out)) $display("FAIL hold_out: got %0d want %0d", o_dbg_rd_outstanding, exp_out); else n_pass++;
        tick();
    endtask

    task automatic test_outstanding_limit();
        int got;
        for (int k = 0; k < 8; k++) begin
            rd_read = 1; rd_address = ADDR_W'($urandom); rd_burstcount = 8'd32;
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                settle();
                if (sd_read && !sd_waitrequest) got = 1;
                tick();
            end
            rd_read = 0;
            n_checks++; if (got != 1) $display("FAIL lim_issue%0d: accepted %0d want 1", k, got); else n_pass++;
        end
        settle();
        n_checks++; if (o_dbg_rd_outstanding !== OUT_W'(exp_out) || exp_out != 256) $display("FAIL lim_full: got %0d want %0d (256)", o_dbg_rd_outstanding, exp_out); else n_pass++;
        tick();
        rd_read = 1; rd_address = ADDR_W'($urandom);
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++; if ({sd_read, rd_waitrequest} !== 2'b01) $display("FAIL lim_stall%0d: got %b want 01", c, {sd_read, rd_waitrequest}); else n_pass++;
            tick();
        end
        sd_readdatavalid = 1; sd_readdata = {$urandom, $urandom};
        settle(); tick();
        sd_readdatavalid = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_checks++; if ({sd_read, rd_waitrequest} !== 2'b01) $display("FAIL lim_stall1_%0d: got %b want 01", c, {sd_read, rd_waitrequest}); else n_pass++;
            tick();
        end
        for (int c = 0; c < 31; c++) begin
            sd_readdatavalid = 1; sd_readdata = {$urandom, $urandom};
            settle();
            n_checks++; if (rd_waitrequest !== 1'b1) $display("FAIL lim_stall31_%0d: got %b want 1", c, rd_waitrequest); else n_pass++;
            tick();
        end
        sd_readdatavalid = 0;
        got = 0;
        for (int c = 0; c < 5 && got == 0; c++) begin
            settle();
            if (sd_read && !sd_waitrequest) got = 1;
            tick();
        end
        rd_read = 0;
        n_checks++; if (got != 1) $display("FAIL lim_ninth: accepted %0d want 1", got); else n_pass++;
        settle();
        n_checks++; if (o_dbg_rd_outstanding !== OUT_W'(exp_out)) $display("FAIL lim_refill: got %0d want %0d", o_dbg_rd_outstanding, exp_out); else n_pass++;
        tick();
        drain(exp_out - 10);
        settle();
        n_checks++; if (o_dbg_rd_outstanding !== OUT_W'(10)) $display("FAIL lim_ten: got %0d want 10", o_dbg_rd_outstanding); else n_pass++;
        tick();
        rd_read = 1; rd_burstcount = 8'd32;
        settle(); tick();
        sd_readdatavalid = 1; sd_readdata = {$urandom, $urandom};
        settle();
        n_checks++; if (sd_read !== 1'b1) $display("FAIL same_cycle_cmd: got %b want 1", sd_read); else n_pass++;
        tick();
        sd_readdatavalid = 0; rd_read = 0;
        settle();
        n_checks++; if (o_dbg_rd_outstanding !== OUT_W'(41) || exp_out != 41) $display("FAIL same_cycle_out: got %0d model %0d want 41", o_dbg_rd_outstanding, exp_out); else n_pass++;
        tick();
        drain(41);
        settle();
        n_checks++; if (busy !== 1'b0) $display("FAIL lim_busy_end: got %b want 0", busy); else n_pass++;
        tick();
    endtask

    task automatic test_zero_burst();
        int beats = 0;
        wr_write = 1; wr_address = ADDR_W'($urandom); wr_burstcount = 8'd0;
        settle(); tick();
        settle();
        n_checks++; if (sd_write !== 1'b1 || sd_burstcount !== 8'd1) $display("FAIL zb_cmd: got %b/%0d want 1/1", sd_write, sd_burstcount); else n_pass++;
        tick();
        wr_write = 0;
        settle();
        n_checks++; if (o_dbg_state !== S_IDLE || busy !== 1'b0) $display("FAIL zb_one_beat: state %0d busy %b want 0/0", o_dbg_state, busy); else n_pass++;
        n_checks++; if (err_zero_burst !== 1'b1) $display("FAIL zb_err_set: got %b want 1", err_zero_burst); else n_pass++;
        tick();
        wr_write = 1; wr_burstcount = 8'd2;
        for (int c = 0; c < 10 && beats < 2; c++) begin
            settle();
            if (sd_write && !sd_waitrequest) beats++;
            tick();
        end
        wr_write = 0;
        settle();
        n_checks++; if (err_zero_burst !== 1'b1) $display("FAIL zb_err_sticky: got %b want 1", err_zero_burst); else n_pass++;
        n_checks++; if (o_dbg_state !== S_IDLE) $display("FAIL zb_idle2: got %0d want 0", o_dbg_state); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        wr_write = 1; wr_address = ADDR_W'($urandom); wr_burstcount = 8'd32;
        settle(); tick();
        for (int i = 0; i < 5; i++) begin
            wr_writedata = {$urandom, $urandom};
            settle(); tick();
        end
        reset_n = 0;
        settle();
        exp_out = 0;
        n_checks++; if ({sd_write, sd_read, wr_waitrequest, rd_waitrequest} !== 4'b0011) $display("FAIL rst_mid_if: got %b want 0011", {sd_write, sd_read, wr_waitrequest, rd_waitrequest}); else n_pass++;
        n_checks++; if ({busy, err_zero_burst, rd_readdatavalid} !== 3'b000) $display("FAIL rst_mid_flags: got %b want 000", {busy, err_zero_burst, rd_readdatavalid}); else n_pass++;
        n_checks++; if (o_dbg_state !== S_IDLE) $display("FAIL rst_mid_state: got %0d want 0", o_dbg_state); else n_pass++;
        wr_write = 0;
        tick();
        reset_n = 1;
        tick();
        settle();
        n_checks++; if (o_dbg_state !== S_IDLE || sd_write !== 1'b0) $display("FAIL rst_mid_after: state %0d sd_write %b want 0/0", o_dbg_state, sd_write); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_write_only();
        test_simultaneous();
        test_write_hold();
        test_outstanding_limit();
        test_zero_burst();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one Avalon-MM SDRAM host port (f2h_sdram) between the frame write channel (wr_*) and the frame read/display channel (rd_*).
- Arbitrates at burst granularity. A write burst is locked until its last beat is accepted. A read is a single command cycle.
- Limits outstanding read beats and routes read data back to the read channel.
- Sits between the frame writer/reader blocks and the HPS SDRAM bridge, all on clk_100.

Parameters:
- ADDR_W, 29: Avalon word address width.
- DATA_W, 64: data width. Byteenable width is DATA_W/8.
- BURST_W, 8: burstcount width.
- MAX_RD_BEATS, 256: maximum read beats outstanding (issued but not yet returned).

Ports:
- clk_100  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- wr_write  in  1  write request / beat valid
- wr_address  in  ADDR_W  burst start address, sampled on the first beat
- wr_burstcount  in  BURST_W  burst length, sampled on the first beat
- wr_writedata  in  DATA_W  beat data
- wr_byteenable  in  DATA_W/8  beat byte enables
- wr_waitrequest  out  1  stall to write channel
- rd_read  in  1  read command request
- rd_address  in  ADDR_W  read burst address
- rd_burstcount  in  BURST_W  read burst length
- rd_waitrequest  out  1  stall to read channel
- rd_readdata  out  DATA_W  returned data
- rd_readdatavalid  out  1  returned beat valid
- sd_write, sd_read  out  1  to SDRAM port
- sd_address  out  ADDR_W  to SDRAM port
- sd_burstcount  out  BURST_W  to SDRAM port
- sd_writedata  out  DATA_W  to SDRAM port
- sd_byteenable  out  DATA_W/8  to SDRAM port
- sd_waitrequest  in  1  from SDRAM port
- sd_readdata  in  DATA_W  from SDRAM port
- sd_readdatavalid  in  1  from SDRAM port
- busy  out  1  write burst in progress, or read beats outstanding
- err_zero_burst  out  1  sticky: a burstcount of 0 was seen

Behaviour:
- Reset (async, reset_n=0): state IDLE, grant none, last_grant=READ (so write wins the first tie), beat counters 0, err_zero_burst 0.
- Reset outputs: sd_write=0, sd_read=0, wr_waitrequest=1, rd_waitrequest=1, busy=0, rd_readdatavalid=0.
- Reset mid-burst discards the burst. No completion is generated for it.
- States: IDLE, WR_BURST, RD_CMD. Grant is registered. Slave-side outputs are a combinational mux of the granted channel. The non-granted channel sees waitrequest=1. With no grant, sd_write and sd_read are 0.
- rd_eligible = rd_read AND (rd_outstanding + eff_rd_burstcount <= MAX_RD_BEATS).
- IDLE:
  - Only wr_write asserted -> WR_BURST next cycle.
  - Only rd_eligible asserted -> RD_CMD next cycle.
  - Both asserted -> the channel not equal to last_grant wins (round robin).
  - Nothing asserted -> stay in IDLE.
  - Latency from request to command on sd_*: 1 cycle.
- WR_BURST:
  - On the first accepted beat (sd_write & !sd_waitrequest), load wr_beats_left = eff_burstcount - 1.
  - Each later accepted beat decrements wr_beats_left.
  - The grant is held while wr_write is low between beats. A read is never interleaved inside a write burst.
  - On the cycle the last beat is accepted, the next grant is decided by the IDLE rules, with write excluded for that decision. It takes effect the next cycle, giving zero idle cycles. If there is no read request, go to IDLE.
  - Set last_grant=WRITE.
- RD_CMD:
  - When sd_read & !sd_waitrequest: add eff_burstcount to rd_outstanding and set last_grant=READ.
  - Next grant is decided the same way, with read excluded for that decision.
- eff_burstcount = burstcount, or 1 if burstcount==0. A zero burstcount also sets err_zero_burst, which stays set until reset.
- rd_readdata / rd_readdatavalid = sd_readdata / sd_readdatavalid passed through combinationally. Each valid beat decrements rd_outstanding.
- If a read command is accepted and a beat returns in the same cycle, the net update is +eff_burstcount-1.
- rd_outstanding width is clog2(MAX_RD_BEATS)+1. It never exceeds MAX_RD_BEATS.
- A readdatavalid with rd_outstanding==0 is ignored: the counter is held at 0.
- busy = (state==WR_BURST) OR (rd_outstanding != 0).

Test Plan:
- Write only: burstcount=32, wr_write held high with 3 random sd_waitrequest stalls -> exactly 32 beats on sd_write in order, sd_address latched at start; grant released the cycle after beat 32; busy low afterwards.
- Simultaneous requests from reset, write burst 4 and read burst 8 -> write granted first; read command on sd_read the cycle after the 4th write beat is accepted; then a new write request is granted next (round robin).
- Write burst of 16 with wr_write deasserted for 5 cycles mid-burst while rd_read is high -> no sd_read until all 16 beats are done; rd_waitrequest stays high throughout.
- MAX_RD_BEATS=256: issue 8 reads of 32, no data returned -> 9th read is stalled (rd_waitrequest=1); return 1 beat -> still stalled; return 32 beats total -> 9th read accepted.
- Read accepted in the same cycle as a returning beat with rd_outstanding=10 and burst 32 -> rd_outstanding=41.
- wr_burstcount=0 -> treated as a 1-beat burst, err_zero_burst=1 and sticky; reset_n pulsed mid 32-beat burst -> all outputs at reset values, state IDLE.
